// File: rtl/sccb_init_seq.sv
// sccb_init_seq: table-driven SCCB/I2C register-write sequencer for camera bring-up.
//
// Walks an external register table, splitting each {reg_addr, data} entry into
// byte-controller commands, checks slave ACKs, retries failed entries and
// executes delay entries (reg_addr == 16'hFFFF, data = milliseconds).
//
// Ports:
//   clk, nReset        clock, asynchronous active-low reset
//   rst_i              synchronous active-high reset, same effect as nReset
//   init_start_i       one-cycle pulse, starts the sequence from index 0 when idle
//   tbl_idx_o          table index; tbl_data_i is valid one cycle after it changes
//   start_o, stop_o, read_o, write_o, ack_in_o, din_o
//                      byte-controller command interface
//   cmd_ack_i, ack_out_i, dout_i, i2c_al_i
//                      byte-controller status (completion, received ACK, read byte,
//                      arbitration lost)
//   busy_o, done_o, error_o, err_idx_o
//                      sequence status; done/error are sticky until the next start
//
// Optional feature (macro SCCB_READBACK_EN): every written register is read back
// and compared; mismatches are retried and counted on mismatch_cnt_o.
module sccb_init_seq #(
    parameter logic [6:0]  DEV_ADDR   = 7'h3C,
    parameter logic [7:0]  TBL_LEN    = 8'd255,
    parameter logic [15:0] CLK_PER_MS = 16'd50000,
    parameter logic [1:0]  MAX_RETRY  = 2'd3
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic        rst_i,
    input  logic        init_start_i,
    output logic [7:0]  tbl_idx_o,
    input  logic [23:0] tbl_data_i,
    output logic        start_o,
    output logic        stop_o,
    output logic        read_o,
    output logic        write_o,
    output logic        ack_in_o,
    output logic [7:0]  din_o,
    input  logic        cmd_ack_i,
    input  logic        ack_out_i,
    input  logic [7:0]  dout_i,
    input  logic        i2c_al_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
`ifdef SCCB_READBACK_EN
    output logic [7:0]  mismatch_cnt_o,
`endif
    output logic [7:0]  err_idx_o
);

    typedef enum logic [4:0] {
        StIdle, StFetch, StDecode, StWDev, StWRhi, StWRlo, StWDat, StGap, StAbort,
        StDelay, StNext, StDone, StErr, StRRhi, StRRlo, StRDev, StRDat
    } state_e;

    state_e      state_q, gap_next_q;
    logic        rb_phase_q;  // R_RHI sends two bytes: 0 = device address, 1 = reg_hi
    logic [7:0]  tbl_idx_q;
    logic [15:0] reg_addr_q;
    logic [7:0]  data_q;
    logic [1:0]  retry_q;
    logic [7:0]  ms_cnt_q;
    logic [15:0] cyc_cnt_q;
    logic        start_q, stop_q, read_q, write_q;
    logic [7:0]  din_q;
    logic        busy_q, done_q, error_q;
    logic [7:0]  err_idx_q;
`ifdef SCCB_READBACK_EN
    logic [7:0]  mismatch_cnt_q;
`endif

    state_e succ_next, nack_next;
    logic   cmd_failed;
    logic   exhausted;

    // Command word issued on entry to a bus state: {start, stop, read, write, din}.
    function automatic logic [11:0] bus_cmd(input state_e st, input logic phase,
                                            input logic [15:0] ra, input logic [7:0] dat);
        case (st)
            StWDev:  bus_cmd = {4'b1001, DEV_ADDR, 1'b0};
            StWRhi:  bus_cmd = {4'b0001, ra[15:8]};
            StWRlo:  bus_cmd = {4'b0001, ra[7:0]};
            StWDat:  bus_cmd = {4'b0101, dat};
            StAbort: bus_cmd = {4'b0100, 8'h00};
            StRRhi:  bus_cmd = phase ? {4'b0001, ra[15:8]} : {4'b1001, DEV_ADDR, 1'b0};
            StRRlo:  bus_cmd = {4'b0101, ra[7:0]};
            StRDev:  bus_cmd = {4'b1001, DEV_ADDR, 1'b1};
            StRDat:  bus_cmd = {4'b0110, 8'h00};
            default: bus_cmd = 12'h000;
        endcase
    endfunction

    assign exhausted = (retry_q == MAX_RETRY);

    // Per bus state: where to go after a good byte, where a failed one leads, and
    // what counts as a failure.
    always_comb begin
        succ_next  = StNext;
        nack_next  = StWDev;
        cmd_failed = ack_out_i;
        case (state_q)
            StWDev: begin succ_next = StWRhi; nack_next = StAbort; end
            StWRhi: begin succ_next = StWRlo; nack_next = StAbort; end
            StWRlo: begin succ_next = StWDat; nack_next = StAbort; end
            StWDat: begin
`ifdef SCCB_READBACK_EN
                succ_next = StRRhi;
`else
                succ_next = StNext;
`endif
            end
            StAbort: begin succ_next = StWDev; cmd_failed = 1'b0; end
            StRRhi: begin
                succ_next = rb_phase_q ? StRRlo : StRRhi;
                nack_next = StAbort;
            end
            StRRlo: succ_next = StRDev;
            StRDev: begin succ_next = StRDat; nack_next = StAbort; end
            StRDat: cmd_failed = (dout_i != data_q);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= StIdle;
            gap_next_q <= StIdle;
            rb_phase_q <= 1'b0;
            tbl_idx_q  <= 8'd0;
            reg_addr_q <= 16'd0;
            data_q     <= 8'd0;
            retry_q    <= 2'd0;
            ms_cnt_q   <= 8'd0;
            cyc_cnt_q  <= 16'd0;
            {start_q, stop_q, read_q, write_q, din_q} <= 12'h000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_idx_q  <= 8'd0;
`ifdef SCCB_READBACK_EN
            mismatch_cnt_q <= 8'd0;
`endif
        end else if (rst_i) begin
            state_q    <= StIdle;
            gap_next_q <= StIdle;
            rb_phase_q <= 1'b0;
            tbl_idx_q  <= 8'd0;
            reg_addr_q <= 16'd0;
            data_q     <= 8'd0;
            retry_q    <= 2'd0;
            ms_cnt_q   <= 8'd0;
            cyc_cnt_q  <= 16'd0;
            {start_q, stop_q, read_q, write_q, din_q} <= 12'h000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_idx_q  <= 8'd0;
`ifdef SCCB_READBACK_EN
            mismatch_cnt_q <= 8'd0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (init_start_i) begin
                        done_q    <= 1'b0;
                        error_q   <= 1'b0;
                        err_idx_q <= 8'd0;
                        retry_q   <= 2'd0;
                        tbl_idx_q <= 8'd0;
                        busy_q    <= 1'b1;
                        state_q   <= StFetch;
                    end
                end
                StFetch: state_q <= StDecode;
                StDecode: begin
                    reg_addr_q <= tbl_data_i[23:8];
                    data_q     <= tbl_data_i[7:0];
                    if (tbl_data_i[23:8] == 16'hFFFF) begin
                        ms_cnt_q  <= tbl_data_i[7:0];
                        cyc_cnt_q <= 16'd0;
                        state_q   <= StDelay;
                    end else begin
                        {start_q, stop_q, read_q, write_q, din_q} <=
                            bus_cmd(StWDev, 1'b0, tbl_data_i[23:8], tbl_data_i[7:0]);
                        state_q <= StWDev;
                    end
                end
                StWDev, StWRhi, StWRlo, StWDat, StAbort, StRRhi, StRRlo, StRDev, StRDat: begin
                    if (i2c_al_i || cmd_ack_i) begin
                        {start_q, stop_q, read_q, write_q, din_q} <= 12'h000;
                    end
                    if (i2c_al_i) begin
                        // Lost the bus: someone else owns it, so no abort stop.
                        rb_phase_q <= 1'b0;
                        if (exhausted) begin
                            err_idx_q <= tbl_idx_q;
                            state_q   <= StErr;
                        end else begin
                            retry_q    <= retry_q + 2'd1;
                            gap_next_q <= StWDev;
                            state_q    <= StGap;
                        end
                    end else if (cmd_ack_i) begin
                        if (cmd_failed) begin
`ifdef SCCB_READBACK_EN
                            if (state_q == StRDat && mismatch_cnt_q != 8'hFF) begin
                                mismatch_cnt_q <= mismatch_cnt_q + 8'd1;
                            end
`endif
                            rb_phase_q <= 1'b0;
                            if (exhausted) begin
                                err_idx_q <= tbl_idx_q;
                                state_q   <= StErr;
                            end else begin
                                retry_q    <= retry_q + 2'd1;
                                gap_next_q <= nack_next;
                                state_q    <= StGap;
                            end
                        end else begin
                            rb_phase_q <= (state_q == StRRhi) && !rb_phase_q;
                            gap_next_q <= succ_next;
                            state_q    <= StGap;
                        end
                    end
                end
                StGap: begin
                    // Next command is loaded here so the bus sees exactly one idle cycle.
                    {start_q, stop_q, read_q, write_q, din_q} <=
                        bus_cmd(gap_next_q, rb_phase_q, reg_addr_q, data_q);
                    state_q <= gap_next_q;
                end
                StDelay: begin
                    if (ms_cnt_q == 8'd0) begin
                        state_q <= StNext;
                    end else if (cyc_cnt_q == CLK_PER_MS - 16'd1) begin
                        cyc_cnt_q <= 16'd0;
                        ms_cnt_q  <= ms_cnt_q - 8'd1;
                    end else begin
                        cyc_cnt_q <= cyc_cnt_q + 16'd1;
                    end
                end
                StNext: begin
                    retry_q <= 2'd0;
                    if (tbl_idx_q == TBL_LEN - 8'd1) begin
                        state_q <= StDone;
                    end else begin
                        tbl_idx_q <= tbl_idx_q + 8'd1;
                        state_q   <= StFetch;
                    end
                end
                StDone: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                StErr: begin
                    error_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tbl_idx_o = tbl_idx_q;
    assign start_o   = start_q;
    assign stop_o    = stop_q;
    assign read_o    = read_q;
    assign write_o   = write_q;
    // Only single-byte reads are issued, so the master always NACKs.
    assign ack_in_o  = 1'b1;
    assign din_o     = din_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign error_o   = error_q;
    assign err_idx_o = err_idx_q;
`ifdef SCCB_READBACK_EN
    assign mismatch_cnt_o = mismatch_cnt_q;
`endif

endmodule

// File: tb/tb_sccb_init_seq.sv
// Self-checking bench for sccb_init_seq: a byte-controller/slave model logs every
// completed command as {start, stop, read, write, din} and directed tests compare
// the log and status outputs against hand-written expectations.
module tb_sccb_init_seq;

    logic        clk = 1'b0;
    logic        nReset;
    logic        rst;
    logic        init_start;
    logic [7:0]  tbl_idx;
    logic [23:0] tbl_data;
    logic        start, stop, read, write, ack_in;
    logic [7:0]  din;
    logic        cmd_ack;
    logic        ack_out;
    logic [7:0]  dout;
    logic        i2c_al;
    logic        busy, done, error;
    logic [7:0]  err_idx;
`ifdef SCCB_READBACK_EN
    logic [7:0]  mismatch_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [23:0] tbl [0:1];
    logic [11:0] ev_q [$];
    logic [11:0] exp_q [$];
    bit          nack_all;
    int          nack_at;
    bit          corrupt_once;
    logic [7:0]  last_data;

    always #5 clk = ~clk;

    sccb_init_seq #(
        .DEV_ADDR   (7'h3C),
        .TBL_LEN    (8'd2),
        .CLK_PER_MS (16'd10),
        .MAX_RETRY  (2'd3)
    ) dut (
        .clk          (clk),
        .nReset       (nReset),
        .rst_i        (rst),
        .init_start_i (init_start),
        .tbl_idx_o    (tbl_idx),
        .tbl_data_i   (tbl_data),
        .start_o      (start),
        .stop_o       (stop),
        .read_o       (read),
        .write_o      (write),
        .ack_in_o     (ack_in),
        .din_o        (din),
        .cmd_ack_i    (cmd_ack),
        .ack_out_i    (ack_out),
        .dout_i       (dout),
        .i2c_al_i     (i2c_al),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error),
`ifdef SCCB_READBACK_EN
        .mismatch_cnt_o (mismatch_cnt),
`endif
        .err_idx_o    (err_idx)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_events(input string tag);
        check_eq({tag, "_count"}, ev_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check_eq($sformatf("%s_ev%0d", tag, i),
                     (i < ev_q.size()) ? 32'(ev_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
        end
    endtask

    // Table memory: data follows the index one cycle later.
    initial begin
        tbl_data = 24'h0;
        forever begin
            @(posedge clk); #1;
            tbl_data = tbl[tbl_idx[0]];
        end
    end

    // Byte controller + slave: acks each command after two cycles.
    initial begin
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        cmd_ack = 1'b0;
        ack_out = 1'b0;
        dout = 8'h00;
        last_data = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (cmd_ack) begin
                cmd_ack = 1'b0;
                check_eq("gap_idle", {start, stop, read, write}, 4'b0000);
            end else if (start || stop || read || write) begin
                cnt++;
                if (cnt == 2) begin
                    cnt = 0;
                    if (start) pos = 0;
                    if (write && pos == 3) last_data = din;
                    ack_out = nack_all || (ev_q.size() == nack_at);
                    if (read) begin
                        dout = corrupt_once ? (last_data ^ 8'h03) : last_data;
                        corrupt_once = 1'b0;
                    end
                    ev_q.push_back({start, stop, read, write, din});
                    pos++;
                    cmd_ack = 1'b1;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Runs one sequence; lat = cycles from the start pulse to the first command.
    task automatic run_seq(input string tag, input bit repulse, output int lat);
        int n;
        lat = -1;
        @(posedge clk); #1 init_start = 1'b1;
        @(posedge clk); #1 init_start = 1'b0;
        check_eq({tag, "_busy_rise"}, busy, 1'b1);
        check_eq({tag, "_done_clr"}, done, 1'b0);
        n = 0;
        while (!(done || error) && n < 5000) begin
            @(posedge clk); #1;
            n++;
            if (lat < 0 && (start || stop || read || write)) lat = n;
            if (repulse) init_start = (n == 5);
        end
        init_start = 1'b0;
        check_eq({tag, "_no_timeout"}, n < 5000, 1'b1);
        check_eq({tag, "_busy_fall"}, busy, 1'b0);
    endtask

    initial begin
        int lat_base, lat_dly, n;
        nReset = 1'b0;
        rst = 1'b0;
        init_start = 1'b0;
        i2c_al = 1'b0;
        nack_all = 1'b0;
        nack_at = -1;
        corrupt_once = 1'b0;
        tbl[0] = 24'h300882;
        tbl[1] = 24'h310303;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cmd", {start, stop, read, write}, 4'b0000);
        check_eq("rst_ack_in", ack_in, 1'b1);
        check_eq("rst_din", din, 8'h00);
        check_eq("rst_idx", tbl_idx, 8'h00);
        check_eq("rst_flags", {busy, done, error}, 3'b000);
        check_eq("rst_err_idx", err_idx, 8'h00);
        nReset = 1'b1;

        // Plain two-entry run; a second start pulse mid-run must be ignored.
        ev_q.delete();
        run_seq("t1", 1'b1, lat_base);
        check_eq("t1_done", done, 1'b1);
        check_eq("t1_error", error, 1'b0);
        check_eq("t1_idx", tbl_idx, 8'd1);
`ifndef SCCB_READBACK_EN
        exp_q = '{12'h978, 12'h130, 12'h108, 12'h582, 12'h978, 12'h131, 12'h103, 12'h503};
        check_events("t1");
`endif

        // NACK on reg_hi of entry 0 once: abort stop, then resend from 78.
        ev_q.delete();
        nack_at = 1;
        run_seq("t2", 1'b0, n);
        nack_at = -1;
        check_eq("t2_done", done, 1'b1);
        check_eq("t2_error", error, 1'b0);
`ifndef SCCB_READBACK_EN
        exp_q = '{12'h978, 12'h130, 12'h400, 12'h978, 12'h130, 12'h108, 12'h582,
                  12'h978, 12'h131, 12'h103, 12'h503};
        check_events("t2");
`endif

        // Slave NACKs everything: four attempts, then error on entry 0.
        ev_q.delete();
        nack_all = 1'b1;
        run_seq("t3", 1'b0, n);
        nack_all = 1'b0;
        check_eq("t3_error", error, 1'b1);
        check_eq("t3_done", done, 1'b0);
        check_eq("t3_err_idx", err_idx, 8'd0);
        exp_q = '{12'h978, 12'h400, 12'h978, 12'h400, 12'h978, 12'h400, 12'h978};
        check_events("t3");

        // Delay entry of 2 ms at 10 clk/ms, then a normal write.
        ev_q.delete();
        tbl[0] = 24'hFFFF02;
        tbl[1] = 24'h300882;
        run_seq("t4", 1'b0, lat_dly);
        $display("delay test: first command after %0d cycles, baseline %0d", lat_dly, lat_base);
        // Extra latency = delay (20 +/- 1) + NEXT + FETCH/DECODE of the next entry.
        check_eq("t4_delay_window", (lat_dly - lat_base >= 22) && (lat_dly - lat_base <= 24), 1'b1);
        check_eq("t4_done", done, 1'b1);
        check_eq("t4_first_cmd", (ev_q.size() > 0) ? 32'(ev_q[0]) : 32'hFFFF_FFFF, 32'h978);

        // Arbitration lost during W_RLO of entry 0.
        ev_q.delete();
        tbl[0] = 24'h300882;
        tbl[1] = 24'h310303;
        @(posedge clk); #1 init_start = 1'b1;
        @(posedge clk); #1 init_start = 1'b0;
        n = 0;
        while (!(write && din == 8'h08) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("t5_found_rlo", n < 200, 1'b1);
        i2c_al = 1'b1;
        @(posedge clk); #1;
        i2c_al = 1'b0;
        check_eq("t5_cmd_dropped", {start, stop, read, write}, 4'b0000);
        n = 0;
        while (!(done || error) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("t5_no_timeout", n < 5000, 1'b1);
        check_eq("t5_done", done, 1'b1);
        check_eq("t5_restart", (ev_q.size() > 2) ? 32'(ev_q[2]) : 32'hFFFF_FFFF, 32'h978);
`ifndef SCCB_READBACK_EN
        exp_q = '{12'h978, 12'h130, 12'h978, 12'h130, 12'h108, 12'h582,
                  12'h978, 12'h131, 12'h103, 12'h503};
        check_events("t5");
`endif

`ifdef SCCB_READBACK_EN
        // First readback returns 0x81 for 0x82: counted and retried.
        ev_q.delete();
        corrupt_once = 1'b1;
        run_seq("t6", 1'b0, n);
        check_eq("t6_mismatch_cnt", mismatch_cnt, 8'd1);
        check_eq("t6_done", done, 1'b1);
        check_eq("t6_error", error, 1'b0);
        exp_q = '{12'h978, 12'h130, 12'h108, 12'h582, 12'h978, 12'h130, 12'h508, 12'h979,
                  12'h600,
                  12'h978, 12'h130, 12'h108, 12'h582, 12'h978, 12'h130, 12'h508, 12'h979,
                  12'h600,
                  12'h978, 12'h131, 12'h103, 12'h503, 12'h978, 12'h131, 12'h503, 12'h979,
                  12'h600};
        check_events("t6");
`endif

        // Synchronous reset mid-transaction returns to idle with the bus released.
        @(posedge clk); #1 init_start = 1'b1;
        @(posedge clk); #1 init_start = 1'b0;
        n = 0;
        while (!write && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("t7_found_write", n < 200, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("t7_cmd", {start, stop, read, write}, 4'b0000);
        check_eq("t7_flags", {busy, done, error}, 3'b000);
        check_eq("t7_idx", tbl_idx, 8'd0);
        repeat (5) @(posedge clk);
        #1;
        check_eq("t7_stays_idle", {busy, start, write}, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
